// File: rtl/gol_row_if.sv
// gol_row_if: row stream, configuration and status signals of gol_row_engine.
interface gol_row_if #(
   parameter int W = 16,
   parameter int H = 16
);
   logic                 i_wrap;
   logic [8:0]           i_birth;
   logic [8:0]           i_survive;
   logic                 i_row_valid;
   logic                 o_row_ready;
   logic [W-1:0]         i_row;
   logic                 o_row_valid;
   logic                 i_row_ready;
   logic [W-1:0]         o_row;
   logic [$clog2(H)-1:0] o_row_idx;
   logic                 o_busy;
   logic                 o_gen_done;
   modport slave (
      input  i_wrap, i_birth, i_survive, i_row_valid, i_row, i_row_ready,
      output o_row_ready, o_row_valid, o_row, o_row_idx, o_busy, o_gen_done
   );
   modport master (
      output i_wrap, i_birth, i_survive, i_row_valid, i_row, i_row_ready,
      input  o_row_ready, o_row_valid, o_row, o_row_idx, o_busy, o_gen_done
   );
endinterface

// File: rtl/gol_row_engine.sv
// gol_row_engine: streaming Game-of-Life generation over a W x H grid, one row per beat.
module gol_row_engine #(
   parameter int W = 16,
   parameter int H = 16
) (
   input logic      i_clk,
   input logic      i_rst,
   gol_row_if.slave rif
);
   localparam int KW = $clog2(H);
   typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
   state_t        state_q, state_d;
   logic [KW-1:0] k_q, k_d, idx_q, idx_d;
   logic [W-1:0]  top_q, top_d, mid_q, mid_d, first_q, first_d, second_q, second_d, row_q, row_d;
   logic          wrap_q, wrap_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
   logic [8:0]    birth_q, birth_d, surv_q, surv_d;
   logic [1:0]    f_q, f_d;
   logic          slot, ready, in_hs, out_hs;

   function automatic logic [W-1:0] gen(input logic [W-1:0] a, c, b, input logic w,
                                        input logic [8:0] bm, sm);
      logic [W-1:0] al, ar, cl, cr, bl, br, r;
      logic [3:0]   n;
      // bit x of *l / *r holds column x-1 / x+1; the edge bit is dead unless wrapping
      al = {a[W-2:0], w & a[W-1]};
      ar = {w & a[0], a[W-1:1]};
      cl = {c[W-2:0], w & c[W-1]};
      cr = {w & c[0], c[W-1:1]};
      bl = {b[W-2:0], w & b[W-1]};
      br = {w & b[0], b[W-1:1]};
      r = '0;
      for (int x = 0; x < W; x++) begin
         n = 4'(al[x]) + 4'(a[x]) + 4'(ar[x]) + 4'(cl[x]) + 4'(cr[x])
           + 4'(bl[x]) + 4'(b[x]) + 4'(br[x]);
         r[x] = c[x] ? sm[n] : bm[n];
      end
      return r;
   endfunction

   always_comb begin
      slot     = !valid_q || rif.i_row_ready;
      ready    = !i_rst && state_q != FLUSH && slot;
      in_hs    = rif.i_row_valid && ready;
      out_hs   = valid_q && rif.i_row_ready;
      state_d  = state_q;
      k_d      = k_q;
      idx_d    = idx_q;
      top_d    = top_q;
      mid_d    = mid_q;
      first_d  = first_q;
      second_d = second_q;
      row_d    = row_q;
      wrap_d   = wrap_q;
      birth_d  = birth_q;
      surv_d   = surv_q;
      busy_d   = busy_q;
      f_d      = f_q;
      valid_d  = out_hs ? 1'b0 : valid_q;
      done_d   = 1'b0;
      if (in_hs) begin
         top_d = mid_q;
         mid_d = rif.i_row;
         k_d   = (k_q == KW'(H-1)) ? '0 : k_q + KW'(1);
         if (k_q == '0) begin
            wrap_d  = rif.i_wrap;
            birth_d = rif.i_birth;
            surv_d  = rif.i_survive;
            first_d = rif.i_row;
            busy_d  = 1'b1;
            state_d = RUN;
         end
         if (k_q == KW'(1))
            second_d = rif.i_row;
         if (k_q == KW'(H-1)) begin
            state_d = FLUSH;
            f_d     = '0;
         end
         // with wrap, row 0 needs row H-1 above it, so it is deferred to the flush
         if (k_q != '0 && !(wrap_q && k_q == KW'(1))) begin
            valid_d = 1'b1;
            row_d   = gen(k_q == KW'(1) ? '0 : top_q, mid_q, rif.i_row, wrap_q, birth_q, surv_q);
            idx_d   = k_q - KW'(1);
         end
      end
      if (state_q == FLUSH) begin
         if (slot && f_q == 2'd0) begin
            valid_d = 1'b1;
            row_d   = gen(top_q, mid_q, wrap_q ? first_q : '0, wrap_q, birth_q, surv_q);
            idx_d   = KW'(H-1);
            f_d     = 2'd1;
         end else if (slot && f_q == 2'd1 && wrap_q) begin
            valid_d = 1'b1;
            row_d   = gen(mid_q, first_q, second_q, wrap_q, birth_q, surv_q);
            idx_d   = '0;
            f_d     = 2'd2;
         end else if (out_hs && f_q == (wrap_q ? 2'd2 : 2'd1)) begin
            state_d = FILL;
            done_d  = 1'b1;
            busy_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= FILL;
         k_q      <= '0;
         idx_q    <= '0;
         top_q    <= '0;
         mid_q    <= '0;
         first_q  <= '0;
         second_q <= '0;
         row_q    <= '0;
         wrap_q   <= 1'b0;
         birth_q  <= '0;
         surv_q   <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         f_q      <= '0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         idx_q    <= idx_d;
         top_q    <= top_d;
         mid_q    <= mid_d;
         first_q  <= first_d;
         second_q <= second_d;
         row_q    <= row_d;
         wrap_q   <= wrap_d;
         birth_q  <= birth_d;
         surv_q   <= surv_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         f_q      <= f_d;
      end
   end

   assign rif.o_row_ready = ready;
   assign rif.o_row_valid = valid_q;
   assign rif.o_row       = row_q;
   assign rif.o_row_idx   = idx_q;
   assign rif.o_busy      = busy_q;
   assign rif.o_gen_done  = done_q;
endmodule

// File: tb/tb_gol_row_engine.sv
// tb_gol_row_engine: directed vector table plus random frames against a grid-level model.
module tb_gol_row_engine;
   localparam int W = 8;
   localparam int H = 8;
   typedef logic [W-1:0] grid_t [H];
   typedef struct {
      grid_t      g;
      bit         w;
      logic [8:0] b;
      logic [8:0] s;
      grid_t      exp;
      bit         chg;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   always #5 clk = ~clk;

   gol_row_if #(.W(W), .H(H)) rif();
   gol_row_engine #(.W(W), .H(H)) dut (.i_clk(clk), .i_rst(rst), .rif(rif));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // next generation straight from the rules: 8 neighbours by coordinates
   function automatic grid_t model(input grid_t g, input bit w, input logic [8:0] b, input logic [8:0] s);
      grid_t nx;
      for (int y = 0; y < H; y++)
         for (int x = 0; x < W; x++) begin
            int n = 0;
            for (int dy = -1; dy <= 1; dy++)
               for (int dx = -1; dx <= 1; dx++) begin
                  int yy = y + dy;
                  int xx = x + dx;
                  if (dy == 0 && dx == 0) continue;
                  if (w) begin
                     yy = (yy + H) % H;
                     xx = (xx + W) % W;
                  end else if (yy < 0 || yy >= H || xx < 0 || xx >= W) continue;
                  n += int'(g[yy][xx]);
               end
            nx[y][x] = g[y][x] ? s[n] : b[n];
         end
      return nx;
   endfunction

   task automatic run_frame(input grid_t g, input bit w, input logic [8:0] b, input logic [8:0] s,
                            input grid_t exp, input bit bp, input bit chg, input string tag);
      int r = 0;
      int nout = 0;
      int dones = 0;
      int eidx;
      bit pstall = 0;
      logic [W-1:0] prow = '0;
      logic [2:0] pidx = '0;
      rif.i_wrap = w;
      rif.i_birth = b;
      rif.i_survive = s;
      for (int cyc = 0; cyc < 300 && dones == 0; cyc++) begin
         @(negedge clk);
         rif.i_row_valid = (r < H);
         rif.i_row = g[r % H];
         rif.i_row_ready = bp ? ((cyc >= 6 && cyc < 11) ? 1'b0 : ($urandom % 3 != 0)) : 1'b1;
         if (chg && r >= 1) rif.i_birth = 9'h008;
         #1;
         if (pstall) begin
            chk({tag, " hold_row"}, 32'(rif.o_row), 32'(prow));
            chk({tag, " hold_idx"}, 32'(rif.o_row_idx), 32'(pidx));
         end
         if (rif.o_row_valid && !rif.i_row_ready)
            chk({tag, " stall_ready"}, 32'(rif.o_row_ready), 32'd0);
         pstall = rif.o_row_valid && !rif.i_row_ready;
         prow = rif.o_row;
         pidx = rif.o_row_idx;
         if (rif.o_gen_done) begin
            dones++;
            chk({tag, " busy_at_done"}, 32'(rif.o_busy), 32'd0);
         end
         if (rif.o_row_valid && rif.i_row_ready) begin
            eidx = w ? (nout + 1) % H : nout;
            chk({tag, " idx"}, 32'(rif.o_row_idx), 32'(eidx));
            chk({tag, " row"}, 32'(rif.o_row), 32'(exp[eidx % H]));
            nout++;
         end
         if (rif.i_row_valid && rif.o_row_ready) r++;
      end
      chk({tag, " outputs"}, 32'(nout), 32'(H));
      chk({tag, " gen_done"}, 32'(dones), 32'd1);
      @(negedge clk);
      rif.i_row_valid = 1'b0;
      rif.i_row_ready = 1'b1;
      #1;
      chk({tag, " done_pulse"}, 32'(rif.o_gen_done), 32'd0);
      chk({tag, " idle_valid"}, 32'(rif.o_row_valid), 32'd0);
   endtask

   initial begin
      vec_t vt[4];
      grid_t g, e;
      bit w;
      logic [8:0] b, s;
      int r;
      rif.i_wrap = 1'b0;
      rif.i_birth = 9'h008;
      rif.i_survive = 9'h00C;
      rif.i_row_valid = 1'b0;
      rif.i_row = '0;
      rif.i_row_ready = 1'b1;

      vt[0].g = '{default: '0}; vt[0].g[3] = 8'b00011100;
      vt[0].w = 0; vt[0].b = 9'h008; vt[0].s = 9'h00C; vt[0].chg = 0;
      vt[0].exp = '{default: '0}; vt[0].exp[2] = 8'h08; vt[0].exp[3] = 8'h08; vt[0].exp[4] = 8'h08;
      vt[1].g = '{default: '0}; vt[1].g[0] = 8'b10000011;
      vt[1].w = 1; vt[1].b = 9'h008; vt[1].s = 9'h00C; vt[1].chg = 0;
      vt[1].exp = '{default: '0}; vt[1].exp[7] = 8'h01; vt[1].exp[0] = 8'h01; vt[1].exp[1] = 8'h01;
      vt[2].g = vt[1].g; vt[2].w = 0; vt[2].b = 9'h008; vt[2].s = 9'h00C; vt[2].chg = 0;
      vt[2].exp = '{default: '0};
      vt[3].g = '{default: '0}; vt[3].w = 0; vt[3].b = 9'h001; vt[3].s = 9'h000; vt[3].chg = 1;
      vt[3].exp = '{default: 8'hFF};

      #2;
      chk("reset_valid", 32'(rif.o_row_valid), 32'd0);
      chk("reset_ready", 32'(rif.o_row_ready), 32'd0);
      chk("reset_busy", 32'(rif.o_busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("release_ready", 32'(rif.o_row_ready), 32'd1);

      for (int i = 0; i < 4; i++)
         run_frame(vt[i].g, vt[i].w, vt[i].b, vt[i].s, vt[i].exp, 1'b0, vt[i].chg, $sformatf("vec%0d", i));

      for (int i = 0; i < 6; i++) begin
         for (int y = 0; y < H; y++) g[y] = 8'($urandom);
         w = 1'($urandom);
         b = (i < 3) ? 9'h008 : 9'($urandom);
         s = (i < 3) ? 9'h00C : 9'($urandom);
         e = model(g, w, b, s);
         run_frame(g, w, b, s, e, 1'b1, 1'b0, $sformatf("rnd%0d", i));
      end

      r = 0;
      rif.i_wrap = 1'b1;
      for (int cyc = 0; cyc < 50 && r < 4; cyc++) begin
         @(negedge clk);
         rif.i_row_valid = 1'b1;
         rif.i_row = 8'($urandom);
         #1;
         if (rif.o_row_ready) r++;
      end
      chk("pre_reset_rows", 32'(r), 32'd4);
      @(negedge clk);
      rif.i_row_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("rst_valid", 32'(rif.o_row_valid), 32'd0);
      chk("rst_row", 32'(rif.o_row), 32'd0);
      chk("rst_idx", 32'(rif.o_row_idx), 32'd0);
      chk("rst_busy", 32'(rif.o_busy), 32'd0);
      chk("rst_done", 32'(rif.o_gen_done), 32'd0);
      chk("rst_ready", 32'(rif.o_row_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_release_ready", 32'(rif.o_row_ready), 32'd1);
      for (int y = 0; y < H; y++) g[y] = 8'($urandom);
      e = model(g, 1'b1, 9'h008, 9'h00C);
      run_frame(g, 1'b1, 9'h008, 9'h00C, e, 1'b1, 1'b0, "after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/gol_row_engine.md
# gol_row_engine

Streaming Game-of-Life generation engine for a W×H grid. It accepts one full row per handshake, keeps a three-row sliding window, and emits the next-generation row for every grid row. It generalises the single-cell next-state rule in three ways: runtime-programmable birth/survive masks, selectable toroidal or dead-boundary edges, and parametrised grid size. It sits between the frame-buffer reader and writer, and each pass of a frame computes one generation.

## Interface
- W, 16, grid width in cells; W ≥ 3.
- H, 16, grid height in rows; H ≥ 3.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_wrap  in  1  1 = toroidal edges (horizontal and vertical); 0 = cells outside the grid are dead.
- i_birth  in  9  bit n = a dead cell with n live neighbours becomes live.
- i_survive  in  9  bit n = a live cell with n live neighbours stays live.
- i_row_valid  in  1  input row valid.
- o_row_ready  out  1  input row accepted when both valid and ready are high.
- i_row  in  W  input row; bit x = column x.
- o_row_valid  out  1  output row valid.
- i_row_ready  in  1  downstream ready.
- o_row  out  W  next-generation row.
- o_row_idx  out  $clog2(H)  grid row index of o_row.
- o_busy  out  1  frame in progress.
- o_gen_done  out  1  one-cycle pulse: the generation is complete.

## Operation
- States:
  - FILL: accepting rows, no output pending.
  - RUN: accepting rows and producing outputs.
  - FLUSH: emitting trailing rows; no input is accepted.
  - After the final output handshake, the block returns to FILL.
- Internal row counter k counts accepted rows 0..H-1 and wraps to 0 at the end of the frame.
- Configuration latch:
  - i_wrap, i_birth and i_survive are sampled when row 0 is accepted.
  - The sampled values are held for the whole frame; changes mid-frame are ignored.
- Buffers:
  - r_top and r_mid hold rows k-2 and k-1.
  - r_first and r_second hold rows 0 and 1, used for vertical wrap.
- Cell rule:
  - n = popcount of the 8 neighbours (4-bit, 0..8).
  - next = cell ? survive[n] : birth[n].
  - Defaults used by software: birth = 9'h008, survive = 9'h00C (B3/S23).
- Horizontal edges:
  - Neighbour column x±1 is taken modulo W when wrap = 1.
  - Otherwise a column outside 0..W-1 is dead.
- Output schedule, wrap = 0:
  - Accepting row k ≥ 1 loads output row k-1 (row -1 is dead).
  - FLUSH emits row H-1 with the row below it dead.
  - o_row_idx order: 0..H-1.
- Output schedule, wrap = 1:
  - Accepting row 1 produces no output.
  - Accepting row k ≥ 2 loads output row k-1.
  - FLUSH emits row H-1 (row below = r_first), then row 0 (above = row H-1, below = r_second).
  - o_row_idx order: 1..H-1, then 0.
- Handshakes:
  - o_row_ready = !i_rst && state ∈ {FILL, RUN} && (!o_row_valid || i_row_ready).
  - While o_row_valid && !i_row_ready, o_row and o_row_idx are held stable.
  - No row is dropped or duplicated.
- o_busy: set on acceptance of row 0, cleared with o_gen_done.
- o_gen_done: registered; high for the single cycle after the final output handshake, the same cycle the state returns to FILL.
- Reset at any time:
  - Frame is aborted; all buffers are cleared.
  - State → FILL, k = 0.
  - o_row_valid = 0, o_row = 0, o_row_idx = 0, o_busy = 0, o_gen_done = 0.
  - o_row_ready = 0 while i_rst is high, and 1 in the first cycle after release.

## Timing
- Latency: output row y-1 is valid in the cycle after the handshake of input row y.
- Throughput: one row per cycle when downstream is ready.
- FLUSH takes 1 output beat (wrap = 0) or 2 output beats (wrap = 1), each gated by i_row_ready.
- Minimum frame time:
  - wrap = 0: H + 2 cycles from the row-0 handshake to o_gen_done.
  - wrap = 1: H + 3 cycles from the row-0 handshake to o_gen_done.
- The next frame's row 0 can be accepted in the o_gen_done cycle.
- Simultaneous input and output handshake in RUN: the output register reloads in the same edge, with no bubble.

## Test plan
- Blinker, wrap = 0, W = H = 8, B3/S23, row 3 = 8'b00011100 → o_row = 8'b00001000 for idx 2, 3 and 4, all other rows 0; idx order 0..7; exactly one o_gen_done.
- Wrap corner, wrap = 1, row 0 = 8'b10000011, other rows 0 → bit 0 set in rows 7, 0 and 1, all else 0; idx order 1..7 then 0.
- Same stimulus with wrap = 0 → all eight output rows are 0.
- Rule mask: birth = 9'h001, survive = 0, all-zero grid → every output row = 8'hFF. Changing birth to 9'h008 after row 0 does not alter the result.
- Backpressure: random i_row_ready with 5-cycle stalls mid-frame → o_row and o_row_idx stable during the stalls, o_row_ready low during them, and the output sequence matches the software model exactly.
- Reset after 4 rows accepted → all outputs 0 immediately and o_row_ready high after release; the following full frame matches the model.
